// File: rtl/adc_emu_pkg.sv
// Shared constants and state encoding for the 8-channel serial ADC responder model.
package adc_emu_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int CTRL_BITS   = 8;
    localparam int ADDR_MSB    = 5;
    localparam int ADDR_LSB    = 3;
    localparam int LEAD_ZEROS  = 4;
    localparam int SAMPLE_BITS = 12;
    localparam int NUM_CHAN    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } emu_state_t;

endpackage

// File: rtl/adc_8ch_emu_spi_edge_sync.sv
// Multi-flop synchronizer for one SPI line with rise/fall detect on the last two synced samples.
// SYNC_STAGES must be at least 2; RST_VAL is the idle level of the line.
module spi_edge_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_l,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/adc_8ch_emu.sv
// Device-side SPI responder emulating an 8-channel 12-bit ADC with host-loadable samples.
// Optional build macro ADC_EMU_RAMP_EN: each completed frame bumps the returned sample by RAMP_STEP.
module adc_8ch_emu
    import adc_emu_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [11:0] INIT_VALUE  = 12'h000,
    parameter logic [11:0] RAMP_STEP   = 12'd1
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        SCLK,
    input  logic        CS_ADC,
    input  logic        DIN,
    output logic        DOUT,
    input  logic        wr_en,
    input  logic [2:0]  wr_chan,
    input  logic [11:0] wr_data,
    output logic        frame_done,
    output logic [2:0]  frame_chan,
    output logic        frame_err,
    output logic [1:0]  dbg_state
);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, din_s;
    logic unused_sclk_lvl, unused_cs_lvl, unused_din_rise, unused_din_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_l(rst_l), .line(SCLK),
        .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_l(rst_l), .line(CS_ADC),
        .level(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );
    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_din (
        .clk(clk), .rst_l(rst_l), .line(DIN),
        .level(din_s), .rise(unused_din_rise), .fall(unused_din_fall)
    );

    logic [SAMPLE_BITS-1:0] sample [NUM_CHAN];
    emu_state_t             state;
    logic [3:0]             bit_cnt;
    logic [3:0]             rise_cnt;
    logic [CTRL_BITS-1:0]   ctrl_sr;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [2:0]             ptr;
    logic [FRAME_BITS-1:0]  load_word;

    // ptr only moves at frame end, so the word loaded now is the channel named last frame
    assign load_word = {{LEAD_ZEROS{1'b0}}, sample[ptr]};
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            rise_cnt   <= '0;
            ctrl_sr    <= '0;
            shift_q    <= '0;
            ptr        <= '0;
            DOUT       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_chan <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    DOUT <= 1'b0;
                    if (cs_fall) begin
                        state    <= ST_SHIFT;
                        rise_cnt <= sclk_rise ? 4'd1 : 4'd0;
                        if (sclk_rise)
                            ctrl_sr <= {ctrl_sr[CTRL_BITS-2:0], din_s};
                        // a falling edge coincident with CS fall already counts as bit 15 sent
                        if (sclk_fall) begin
                            shift_q <= load_word << 1;
                            DOUT    <= load_word[FRAME_BITS-2];
                            bit_cnt <= 4'd1;
                        end else begin
                            shift_q <= load_word;
                            DOUT    <= load_word[FRAME_BITS-1];
                            bit_cnt <= 4'd0;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        DOUT      <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        if (sclk_rise && (rise_cnt < 4'(CTRL_BITS))) begin
                            ctrl_sr  <= {ctrl_sr[CTRL_BITS-2:0], din_s};
                            rise_cnt <= rise_cnt + 4'd1;
                        end
                        if (sclk_fall) begin
                            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
                                state      <= ST_DONE;
                                DOUT       <= 1'b0;
                                ptr        <= ctrl_sr[ADDR_MSB:ADDR_LSB];
                                frame_chan <= ptr;
                                frame_done <= 1'b1;
                            end else begin
                                shift_q <= shift_q << 1;
                                DOUT    <= shift_q[FRAME_BITS-2];
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    DOUT <= 1'b0;
                    if (cs_rise)
                        state <= ST_IDLE;
                end
                default: begin
                    DOUT  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Host write is placed after the ramp so a same-cycle write takes priority
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NUM_CHAN; i++)
                sample[i] <= INIT_VALUE;
        end else begin
`ifdef ADC_EMU_RAMP_EN
            if (frame_done)
                sample[frame_chan] <= sample[frame_chan] + RAMP_STEP;
`endif
            if (wr_en)
                sample[wr_chan] <= wr_data;
        end
    end

`ifndef ADC_EMU_RAMP_EN
    logic unused_ramp;
    assign unused_ramp = ^RAMP_STEP;
`endif

endmodule

// File: tb/tb_adc_8ch_emu.sv
// Directed bench for adc_8ch_emu: acts as SPI master and host, compares returned words to a channel model.
module tb_adc_8ch_emu;

  logic        clk;
  logic        rst_l;
  logic        SCLK;
  logic        CS_ADC;
  logic        DIN;
  logic        DOUT;
  logic        wr_en;
  logic [2:0]  wr_chan;
  logic [11:0] wr_data;
  logic        frame_done;
  logic [2:0]  frame_chan;
  logic        frame_err;
  logic [1:0]  dbg_state;

  adc_8ch_emu dut (
    .clk(clk), .rst_l(rst_l), .SCLK(SCLK), .CS_ADC(CS_ADC), .DIN(DIN), .DOUT(DOUT),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data),
    .frame_done(frame_done), .frame_chan(frame_chan), .frame_err(frame_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [11:0] m_samp [8];
  logic [2:0]  m_ptr;
  logic [15:0] exp_q [$];

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_err)  err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks; all driving happens on negedge clk
  task automatic host_write(input logic [2:0] ch, input logic [11:0] dat);
    wr_en = 1'b1; wr_chan = ch; wr_data = dat;
    @(negedge clk);
    wr_en = 1'b0;
    m_samp[ch] = dat;
  endtask

  task automatic run_frame(input logic [7:0] ctrl, input int nbits, input int wr_bit,
                           input logic [2:0] wch, input logic [11:0] wdat, input bit arm,
                           output logic [31:0] rx);
    bit seen;
    rx = '0;
    CS_ADC = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      DIN = (i < 8) ? ctrl[7-i] : 1'b0;
      if (i == wr_bit) begin
        wr_en = 1'b1; wr_chan = wch; wr_data = wdat;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (7) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
      rx = {rx[30:0], DOUT};
      SCLK = 1'b0;
    end
    DIN = 1'b0;
    if (arm) begin
      seen = 1'b0;
      for (int k = 0; k < 16 && !seen; k++) begin
        @(negedge clk);
        if (frame_done) begin
          seen = 1'b1;
          wr_en = 1'b1; wr_chan = wch; wr_data = wdat;
          @(negedge clk);
          wr_en = 1'b0;
        end
      end
      check("arm_done_seen", 32'(seen), 32'd1);
    end
    repeat (8) @(negedge clk);
    CS_ADC = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_check(input string tag, input logic [2:0] addr, input int wr_bit,
                             input logic [11:0] wdat, input bit arm);
    logic [31:0] rx;
    logic [2:0]  ch;
    int          d0;
    ch = m_ptr;
    d0 = done_cnt;
    exp_q.push_back({4'h0, m_samp[ch]});
    run_frame({2'b00, addr, 3'b000}, 16, wr_bit, ch, wdat, arm, rx);
    if (wr_bit >= 0) m_samp[ch] = wdat;
`ifdef ADC_EMU_RAMP_EN
    m_samp[ch] = m_samp[ch] + 12'd1;
`endif
    if (arm) m_samp[ch] = wdat;
    check({tag, "_dout"}, 32'(rx[15:0]), 32'(exp_q.pop_front()));
    check({tag, "_chan"}, 32'(frame_chan), 32'(ch));
    check({tag, "_ndone"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_idle"}, 32'(DOUT), 32'd0);
    m_ptr = addr;
  endtask

  initial begin
    logic [31:0] rx;
    int d0, e0;
    rst_l = 1'b0; SCLK = 1'b0; CS_ADC = 1'b1; DIN = 1'b0;
    wr_en = 1'b0; wr_chan = '0; wr_data = '0;
    for (int i = 0; i < 8; i++) m_samp[i] = 12'h000;
    m_ptr = 3'd0;
    repeat (4) @(negedge clk);
    check("rst_dout", 32'(DOUT), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_chan", 32'(frame_chan), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_l = 1'b1;
    repeat (4) @(negedge clk);

    // basic pipelined addressing
    host_write(3'd0, 12'hABC);
    host_write(3'd5, 12'h5A5);
    frame_check("basic0", 3'd5, -1, 12'h000, 1'b0);
    frame_check("basic1", 3'd0, -1, 12'h000, 1'b0);

    // address sweep
    for (int i = 0; i < 8; i++) host_write(3'(i), 12'h100 + 12'(i));
    d0 = done_cnt; e0 = err_cnt;
    for (int i = 0; i < 8; i++) frame_check($sformatf("sweep%0d", i), 3'(i), -1, 12'h000, 1'b0);
    check("sweep_ndone", 32'(done_cnt - d0), 32'd8);
    check("sweep_nerr", 32'(err_cnt - e0), 32'd0);

    // short frame: CS rises after 9 SCLK
    d0 = done_cnt; e0 = err_cnt;
    run_frame({2'b00, 3'd2, 3'b000}, 9, -1, 3'd0, 12'h000, 1'b0, rx);
    check("abort_nerr", 32'(err_cnt - e0), 32'd1);
    check("abort_ndone", 32'(done_cnt - d0), 32'd0);
    check("abort_dout", 32'(DOUT), 32'd0);
    check("abort_state", 32'(dbg_state), 32'd0);
    frame_check("after_abort", 3'd1, -1, 12'h000, 1'b0);

    // 20 SCLK in one CS window
    d0 = done_cnt;
    exp_q.push_back({4'h0, m_samp[m_ptr]});
    run_frame({2'b00, 3'd4, 3'b000}, 20, -1, 3'd0, 12'h000, 1'b0, rx);
    check("long_dout", 32'(rx[19:4]), 32'(exp_q.pop_front()));
    check("long_tail", 32'(rx[3:0]), 32'd0);
    check("long_ndone", 32'(done_cnt - d0), 32'd1);
    check("long_chan", 32'(frame_chan), 32'(m_ptr));
`ifdef ADC_EMU_RAMP_EN
    m_samp[m_ptr] = m_samp[m_ptr] + 12'd1;
`endif
    m_ptr = 3'd4;

    // mid-frame write to the channel being returned
    frame_check("midwr", 3'd4, 8, 12'hFFF, 1'b0);
    frame_check("midwr_next", 3'd3, -1, 12'h000, 1'b0);

    // repeated reads of ch3 starting at full scale, then a write landing on frame_done
    host_write(3'd3, 12'hFFF);
    frame_check("ch3_a", 3'd3, -1, 12'h000, 1'b0);
    frame_check("ch3_b", 3'd3, -1, 12'h055, 1'b1);
    frame_check("ch3_c", 3'd0, -1, 12'h000, 1'b0);

    // reset in the middle of a frame
    e0 = err_cnt;
    CS_ADC = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_shift", 32'(dbg_state), 32'd1);
    rst_l = 1'b0;
    CS_ADC = 1'b1;
    repeat (4) @(negedge clk);
    rst_l = 1'b1;
    repeat (8) @(negedge clk);
    check("midrst_nerr", 32'(err_cnt - e0), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    for (int i = 0; i < 8; i++) m_samp[i] = 12'h000;
    m_ptr = 3'd0;
    frame_check("post_rst", 3'd6, -1, 12'h000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
